btb_update_ctrl: RTL and testbench

// Write-port scheduler for the BTB. Buffers misprediction updates from EX0 in a small FIFO, issues at most one
// BTB write per cycle and owns a sweep engine that clears every BTB entry after reset and on flush_req.

---
 rtl/btb_update_ctrl_pkg.sv | 25 ++
 rtl/btb_upd_fifo.sv | 83 ++++++++
 rtl/btb_update_ctrl.sv | 159 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_ctrl_pkg.sv
// Shared definitions for the BTB write-port scheduler: FSM state encodings,
// entry field widths and the taken-slot encoding helper.
package btb_update_ctrl_pkg;

    localparam int TPC_W   = 32;
    localparam int TAKEN_W = 2;
    localparam int DROP_W  = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    localparam logic [1:0] BTBC_INIT  = 2'd0;
    localparam logic [1:0] BTBC_IDLE  = 2'd1;
    localparam logic [1:0] BTBC_SWEEP = 2'd2;

    // A taken branch marks the slot of its 4-byte half inside the 8-byte fetch pair
    function automatic logic [TAKEN_W-1:0] taken_slot(input logic taken, input logic pc_bit2);
        logic [TAKEN_W-1:0] slot;
        slot = 2'b00;
        if (taken) begin
            slot = pc_bit2 ? 2'b10 : 2'b01;
        end
        return slot;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update FIFO for the BTB scheduler. Pointers carry one extra wrap
// bit so full and empty are distinguishable; the tail entry can be rewritten
// in place so a newer update for the same BTB index replaces an older one.
module btb_upd_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4,
    parameter int KEY_W = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic                   ovr_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [KEY_W-1:0]       tail_key_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q;
    logic [CW-1:0]    wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q;
    logic [CW-1:0]    rd_ptr_d;
    logic [AW-1:0]    tail_addr;
    logic             full_q;

    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = full_q;
    assign tail_addr  = wr_ptr_q[AW-1:0] - AW'(1);
    assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign tail_key_o = mem_q[tail_addr][WIDTH-1 -: KEY_W];

    // Next pointer values; clear discards everything including this cycle's push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end
    end

    // Pointer and full-flag registers; full is registered from the next occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= ((wr_ptr_d - rd_ptr_d) == DEPTH_C);
        end
    end

    // Storage array; a push writes the slot after the tail, an overwrite replaces the tail
    always_ff @(posedge clk) begin
        if (!clear_i) begin
            if (push_i) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
            end else if (ovr_i) begin
                mem_q[tail_addr] <= din_i;
            end
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler. Mispredicted branches from EX0 are queued and
// written one per cycle; after reset or a flush a sweep engine clears every
// BTB entry first, holding busy so fetch ignores BTB hits meanwhile.
module btb_update_ctrl #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 6,
    parameter int QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic [31:0]            upd_tpc,
    input  logic                   upd_taken,
    input  logic                   upd_dir_fail,
    input  logic                   upd_add_fail,
    input  logic                   flush_req,
    output logic                   btb_we,
    output logic [INDEX_WIDTH-1:0] btb_idx,
    output logic [TAG_WIDTH-1:0]   btb_tag,
    output logic [31:0]            btb_tpc,
    output logic [1:0]             btb_taken,
    output logic                   busy,
    output logic                   q_full,
    output logic [7:0]             drop_cnt
);

    import btb_update_ctrl_pkg::*;

    localparam int CW      = $clog2(QDEPTH) + 1;
    localparam int TPC_LSB = TAKEN_W;
    localparam int TAG_LSB = TPC_LSB + TPC_W;
    localparam int IDX_LSB = TAG_LSB + TAG_WIDTH;
    localparam int ENTRY_W = IDX_LSB + INDEX_WIDTH;
    localparam int PC_TOP  = TAG_WIDTH + INDEX_WIDTH + 2;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [INDEX_WIDTH-1:0] sweep_cnt_q;
    logic [INDEX_WIDTH-1:0] sweep_cnt_d;
    logic [DROP_W-1:0]      drop_q;
    logic [DROP_W-1:0]      drop_d;

    logic                   sweeping;
    logic [INDEX_WIDTH-1:0] new_idx;
    logic [TAG_WIDTH-1:0]   new_tag;
    logic [TAKEN_W-1:0]     new_taken;
    logic [ENTRY_W-1:0]     new_entry;

    logic                   upd_req;
    logic                   pop;
    logic                   tail_popping;
    logic                   coalesce;
    logic                   push;
    logic                   drop;

    logic [ENTRY_W-1:0]     head;
    logic [INDEX_WIDTH-1:0] tail_idx;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   unused_pc_bits;

    assign sweeping  = (state_q != BTBC_IDLE);
    assign new_idx   = upd_pc[INDEX_WIDTH+2:3];
    assign new_tag   = upd_pc[PC_TOP:INDEX_WIDTH+3];
    assign new_taken = taken_slot(upd_taken, upd_pc[2]);
    assign new_entry = {new_idx, new_tag, upd_tpc, new_taken};
    assign unused_pc_bits = ^{upd_pc[31:PC_TOP+1], upd_pc[1:0]};

    // Queue admission: coalesce onto a same-index tail, else push if a slot exists or frees up, else drop
    always_comb begin
        upd_req      = upd_valid & (upd_dir_fail | upd_add_fail) & ~flush_req;
        pop          = ~sweeping & ~fifo_empty;
        tail_popping = pop & (fifo_count == CW'(1));
        coalesce     = upd_req & ~fifo_empty & (tail_idx == new_idx) & ~tail_popping;
        push         = upd_req & ~coalesce & ((fifo_count != CW'(QDEPTH)) | pop);
        drop         = upd_req & ~coalesce & ~push;
    end

    btb_upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH),
        .KEY_W (INDEX_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (push),
        .pop_i      (pop),
        .clear_i    (flush_req),
        .ovr_i      (coalesce),
        .din_i      (new_entry),
        .head_o     (head),
        .tail_key_o (tail_idx),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Sweep sequencing and drop counting; a flush restarts the sweep from index 0 in any state
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        drop_d      = drop_q;
        if (sweeping) begin
            sweep_cnt_d = sweep_cnt_q + INDEX_WIDTH'(1);
            if (sweep_cnt_q == LAST_IDX) begin
                state_d = BTBC_IDLE;
            end
        end
        if (flush_req) begin
            state_d     = BTBC_SWEEP;
            sweep_cnt_d = '0;
        end
        if (drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= BTBC_INIT;
            sweep_cnt_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            drop_q      <= drop_d;
        end
    end

    // Write-port mux: sweep clears take priority, otherwise the FIFO head; all zero while in reset
    always_comb begin
        btb_we    = 1'b0;
        btb_idx   = '0;
        btb_tag   = '0;
        btb_tpc   = '0;
        btb_taken = '0;
        if (rstn) begin
            if (sweeping) begin
                btb_we  = 1'b1;
                btb_idx = sweep_cnt_q;
            end else if (!fifo_empty) begin
                btb_we    = 1'b1;
                btb_idx   = head[IDX_LSB +: INDEX_WIDTH];
                btb_tag   = head[TAG_LSB +: TAG_WIDTH];
                btb_tpc   = head[TPC_LSB +: TPC_W];
                btb_taken = head[0 +: TAKEN_W];
            end
        end
    end

    assign busy     = sweeping;
    assign q_full   = fifo_full;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: a queue-based model of the scheduler is checked
// against the DUT on every falling edge, and directed scenarios add literal
// expectations for the reset sweep, latency, coalescing, drops and flushes.
module tb_btb_update_ctrl;

    localparam int QD = 4;

    typedef struct packed {
        logic [5:0]  idx;
        logic [5:0]  tag;
        logic [31:0] tpc;
        logic [1:0]  taken;
    } ent_t;

    logic        clk;
    logic        rstn;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_tpc;
    logic        upd_taken;
    logic        upd_dir_fail;
    logic        upd_add_fail;
    logic        flush_req;
    logic        btb_we;
    logic [5:0]  btb_idx;
    logic [5:0]  btb_tag;
    logic [31:0] btb_tpc;
    logic [1:0]  btb_taken;
    logic        busy;
    logic        q_full;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    ent_t mq[$];
    int   sweepPos;
    int   mDrops;

    logic [31:0] burstPc   [8] = '{32'h00001008, 32'h00001008, 32'h00001210, 32'h0000A51C,
                                   32'h00000000, 32'h00FF7FFC, 32'h12345678, 32'h00000000};
    logic [31:0] burstTpc  [8] = '{32'h00002000, 32'h00003000, 32'h00004000, 32'h00005000,
                                   32'h00000000, 32'hFFFFFFFC, 32'h00000000, 32'h00000010};
    logic [3:0]  burstCtl  [8] = '{4'b1110, 4'b1001, 4'b1100, 4'b1101,
                                   4'b0000, 4'b1110, 4'b1011, 4'b1101};
    int          sixOrder  [4] = '{1, 2, 3, 5};

    btb_update_ctrl #(
        .INDEX_WIDTH (6),
        .TAG_WIDTH   (6),
        .QDEPTH      (QD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_tpc      (upd_tpc),
        .upd_taken    (upd_taken),
        .upd_dir_fail (upd_dir_fail),
        .upd_add_fail (upd_add_fail),
        .flush_req    (flush_req),
        .btb_we       (btb_we),
        .btb_idx      (btb_idx),
        .btb_tag      (btb_tag),
        .btb_tpc      (btb_tpc),
        .btb_taken    (btb_taken),
        .busy         (busy),
        .q_full       (q_full),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic we, input logic [5:0] idx, input logic [5:0] tag,
                                         input logic [31:0] tpc, input logic [1:0] tk, input logic bsy,
                                         input logic full, input logic [7:0] drp);
        return {7'd0, we, idx, tag, tpc, tk, bsy, full, drp};
    endfunction

    function automatic logic [63:0] actualVec();
        return pack(btb_we, btb_idx, btb_tag, btb_tpc, btb_taken, busy, q_full, drop_cnt);
    endfunction

    function automatic ent_t makeEntry(input logic [31:0] pc, input logic [31:0] tpc, input logic tk);
        ent_t e;
        e.idx   = pc[8:3];
        e.tag   = pc[14:9];
        e.tpc   = tpc;
        e.taken = !tk ? 2'b00 : (pc[2] ? 2'b10 : 2'b01);
        return e;
    endfunction

    // Expected outputs: sweep clears while a sweep is running, otherwise the oldest queued update
    function automatic logic [63:0] modelVec();
        logic [63:0] v;
        if (sweepPos >= 0) begin
            v = pack(1'b1, 6'(sweepPos), 6'd0, 32'd0, 2'd0, 1'b1, mq.size() == QD, 8'(mDrops));
        end else if (mq.size() > 0) begin
            v = pack(1'b1, mq[0].idx, mq[0].tag, mq[0].tpc, mq[0].taken, 1'b0, mq.size() == QD, 8'(mDrops));
        end else begin
            v = pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b0, 1'b0, 8'(mDrops));
        end
        return v;
    endfunction

    task automatic modelReset();
        mq.delete();
        sweepPos = 0;
        mDrops   = 0;
    endtask

    // Advance the model across one clock edge using this cycle's inputs
    task automatic modelStep();
        int   n;
        bit   popped;
        bit   tailPopped;
        bit   acc;
        bit   coal;
        ent_t e;
        n          = mq.size();
        popped     = (sweepPos < 0) && (n > 0);
        tailPopped = popped && (n == 1);
        acc        = upd_valid && (upd_dir_fail || upd_add_fail);
        e          = makeEntry(upd_pc, upd_tpc, upd_taken);
        coal       = acc && (n > 0) && (mq[n-1].idx == e.idx) && !tailPopped;
        if (flush_req) begin
            mq.delete();
            sweepPos = 0;
        end else begin
            if (popped) void'(mq.pop_front());
            if (acc) begin
                if (coal) mq[mq.size()-1] = e;
                else if ((n < QD) || popped) mq.push_back(e);
                else if (mDrops < 255) mDrops++;
            end
            if (sweepPos >= 0) sweepPos = (sweepPos == 63) ? -1 : sweepPos + 1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's worth of inputs just after the rising edge
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] tpc,
                                 input logic tk, input logic df, input logic af, input logic fl);
        @(posedge clk);
        #1;
        upd_valid    = v;
        upd_pc       = pc;
        upd_tpc      = tpc;
        upd_taken    = tk;
        upd_dir_fail = df;
        upd_add_fail = af;
        flush_req    = fl;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after the edge that starts a sweep cycle; counts in-order zero clears until busy drops
    task automatic countSweep(input int first, output int inOrder, output int busyCycles);
        inOrder    = 0;
        busyCycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            busyCycles++;
            if (btb_we && btb_idx == 6'(first + inOrder) && btb_tag == 6'd0 &&
                btb_tpc == 32'd0 && btb_taken == 2'd0) inOrder++;
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                modelReset();
                checkOutput("reset_cycle", actualVec(), pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b1, 1'b0, 8'd0));
            end else begin
                checkOutput("model_cycle", actualVec(), modelVec());
                modelStep();
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int inOrder;
        int busyCycles;

        rstn         = 1'b0;
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_tpc      = '0;
        upd_taken    = 1'b0;
        upd_dir_fail = 1'b0;
        upd_add_fail = 1'b0;
        flush_req    = 1'b0;

        // Reset values and the 64-entry INIT sweep
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", actualVec(), pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b1, 1'b0, 8'd0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        countSweep(0, inOrder, busyCycles);
        checkOutput("init_sweep_in_order", 64'(inOrder), 64'd64);
        checkOutput("init_sweep_busy_len", 64'(busyCycles), 64'd64);
        checkOutput("init_sweep_end", {62'd0, btb_we, busy}, 64'd0);

        // Single update: no write in arrival cycle, head written the next cycle
        applyStimulus(1'b1, 32'h1C000104, 32'h1C000200, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_no_bypass", 64'(btb_we), 64'd0);
        applyIdle();
        @(negedge clk);
        checkOutput("single_write", actualVec(), pack(1'b1, 6'h20, 6'h00, 32'h1C000200, 2'b10, 1'b0, 1'b0, 8'd0));
        applyIdle();
        @(negedge clk);
        checkOutput("single_drained", 64'(btb_we), 64'd0);

        // Back-to-back IDLE traffic: mixed fail kinds, non-fail updates, same index while popping
        for (int i = 0; i < 8; i++) begin
            applyStimulus(burstCtl[i][3], burstPc[i], burstTpc[i], burstCtl[i][2], burstCtl[i][1],
                          burstCtl[i][0], 1'b0);
        end
        repeat (3) applyIdle();

        // Flush with an update in the same cycle, then a second flush at sweep index 30
        applyStimulus(1'b1, 32'h00000400, 32'hDEAD0000, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00000100, 32'h0A000000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00000200, 32'h0B000000, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (28) applyIdle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("sweep_at_30", actualVec(), pack(1'b1, 6'd30, 6'd0, 32'd0, 2'd0, 1'b1, 1'b0, 8'd0));
        applyIdle();
        countSweep(0, inOrder, busyCycles);
        checkOutput("flush_restart_in_order", 64'(inOrder), 64'd64);
        checkOutput("flush_restart_len", 64'(busyCycles), 64'd64);
        checkOutput("flush_queue_cleared", 64'(btb_we), 64'd0);

        // Coalesce: two same-index updates during a sweep leave one write with the newer data
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00000A40, 32'h11110000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00000A44, 32'h22220000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyIdle();
        countSweep(2, inOrder, busyCycles);
        checkOutput("coalesce_sweep_len", 64'(busyCycles), 64'd62);
        checkOutput("coalesce_write", actualVec(), pack(1'b1, 6'h08, 6'h05, 32'h22220000, 2'b10, 1'b0, 1'b0, 8'd0));
        applyIdle();
        @(negedge clk);
        checkOutput("coalesce_single_write", actualVec(), pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b0, 1'b0, 8'd0));

        // Six back-to-back updates over the sweep end: four fill, one dropped, one rides the first pop
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (59) applyIdle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 32'h00001000 + 32'(k * 8), 32'h30000000 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0);
            if (k == 4) begin
                @(negedge clk);
                checkOutput("six_full_at_63", actualVec(), pack(1'b1, 6'd63, 6'd0, 32'd0, 2'd0, 1'b1, 1'b1, 8'd0));
            end
        end
        @(negedge clk);
        checkOutput("six_first_write", actualVec(), pack(1'b1, 6'd0, 6'h08, 32'h30000000, 2'b00, 1'b0, 1'b1, 8'd1));
        for (int j = 0; j < 4; j++) begin
            applyIdle();
            @(negedge clk);
            checkOutput("six_write_order", {25'd0, btb_we, btb_idx, btb_tpc},
                        {25'd0, 1'b1, 6'(sixOrder[j]), 32'h30000000 + 32'(sixOrder[j])});
        end
        applyIdle();
        @(negedge clk);
        checkOutput("six_drained", {55'd0, btb_we, drop_cnt}, {55'd0, 1'b0, 8'd1});

        // Reset while draining with three entries still queued
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h00002000 + 32'(k * 8), 32'h40000000 + 32'(k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyIdle();
        countSweep(4, inOrder, busyCycles);
        checkOutput("drain_first", {31'd0, btb_we, btb_tpc}, {31'd0, 1'b1, 32'h40000000});
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("reset_immediate", actualVec(), pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b1, 1'b0, 8'd0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        countSweep(0, inOrder, busyCycles);
        checkOutput("reinit_sweep_in_order", 64'(inOrder), 64'd64);
        checkOutput("reinit_sweep_len", 64'(busyCycles), 64'd64);
        checkOutput("no_stale_writes", actualVec(), pack(1'b0, 6'd0, 6'd0, 32'd0, 2'd0, 1'b0, 1'b0, 8'd0));
        applyIdle();
        @(negedge clk);
        checkOutput("no_stale_writes_next", 64'(btb_we), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
